// File: rtl/arp_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : arp_ctrl
// Description : ARP transaction controller in front of the arp block. It
//               answers inbound ARP requests and resolves a user target IP
//               with a reply-wait timeout and a bounded number of resends.
//               It also holds the resolved peer MAC/IP for the UDP path.
// Revision    : 1.0 - initial release
// ============================================================================
module arp_ctrl #(
    parameter logic [47:0] DES_MAC      = 48'hff_ff_ff_ff_ff_ff,
    parameter logic [31:0] DES_IP       = {8'd192, 8'd168, 8'd0, 8'd3},
    parameter int          RETRY_CYCLES = 125_000_000,
    parameter int          MAX_RETRY    = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [31:0] tgt_ip,
    input  logic        arp_rx_done,
    input  logic        arp_rx_type,
    input  logic [47:0] src_mac,
    input  logic [31:0] src_ip,
    input  logic        gmii_tx_done,
    output logic        arp_tx_en,
    output logic        arp_tx_type,
    output logic [47:0] des_mac,
    output logic [31:0] des_ip,
    output logic        resolved,
    output logic [47:0] res_mac,
    output logic [31:0] res_ip,
    output logic        timeout_err,
    output logic        busy
);

    localparam int TIMER_W = (RETRY_CYCLES > 1) ? $clog2(RETRY_CYCLES) : 1;
    localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST  = TIMER_W'(RETRY_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        TX_START   = 2'd1,
        TX_WAIT    = 2'd2,
        WAIT_REPLY = 2'd3
    } state_t;

    state_t               state_q,       state_d;
    logic                 ret_wait_q,    ret_wait_d;    // reply being sent from inside a wait
    logic                 pend_rep_q,    pend_rep_d;
    logic [47:0]          rep_mac_q,     rep_mac_d;
    logic [31:0]          rep_ip_q,      rep_ip_d;
    logic                 pend_req_q,    pend_req_d;
    logic [31:0]          tgt_ip_q,      tgt_ip_d;
    logic [RETRY_W-1:0]   retry_q,       retry_d;
    logic [TIMER_W-1:0]   timer_q,       timer_d;
    logic                 tx_en_q,       tx_en_d;
    logic                 tx_type_q,     tx_type_d;
    logic [47:0]          des_mac_q,     des_mac_d;
    logic [31:0]          des_ip_q,      des_ip_d;
    logic                 resolved_q,    resolved_d;
    logic [47:0]          res_mac_q,     res_mac_d;
    logic [31:0]          res_ip_q,      res_ip_d;
    logic                 timeout_err_q, timeout_err_d;
    logic                 busy_q,        busy_d;

    logic rx_req;
    logic rx_match;
    logic resolve;

    assign rx_req   = arp_rx_done & ~arp_rx_type;
    assign rx_match = arp_rx_done &  arp_rx_type & (src_ip == tgt_ip_q);

    // A matching reply counts while waiting, while a reply is sent from inside
    // the wait, and in the cycle our own request finishes transmitting.
    assign resolve = rx_match & ((state_q == WAIT_REPLY) | ret_wait_q |
                                 ((state_q == TX_WAIT) & ~tx_type_q & gmii_tx_done));

    // Next-state, pending-flag and registered-output computation.
    always_comb begin
        state_d       = state_q;
        ret_wait_d    = ret_wait_q;
        pend_rep_d    = pend_rep_q;
        rep_mac_d     = rep_mac_q;
        rep_ip_d      = rep_ip_q;
        pend_req_d    = pend_req_q;
        tgt_ip_d      = tgt_ip_q;
        retry_d       = retry_q;
        timer_d       = timer_q;
        tx_en_d       = 1'b0;
        tx_type_d     = tx_type_q;
        des_mac_d     = des_mac_q;
        des_ip_d      = des_ip_q;
        resolved_d    = resolved_q;
        res_mac_d     = res_mac_q;
        res_ip_d      = res_ip_q;
        timeout_err_d = timeout_err_q;

        case (state_q)
            IDLE: begin
                if (pend_rep_q) begin
                    state_d    = TX_START;
                    tx_en_d    = 1'b1;
                    tx_type_d  = 1'b1;
                    des_mac_d  = rep_mac_q;
                    des_ip_d   = rep_ip_q;
                    pend_rep_d = 1'b0;
                    ret_wait_d = 1'b0;
                end else if (pend_req_q) begin
                    state_d    = TX_START;
                    tx_en_d    = 1'b1;
                    tx_type_d  = 1'b0;
                    des_mac_d  = DES_MAC;
                    des_ip_d   = tgt_ip_q;
                    pend_req_d = 1'b0;
                    ret_wait_d = 1'b0;
                end
            end
            TX_START: begin
                state_d = TX_WAIT;
                if (resolve) ret_wait_d = 1'b0;
            end
            TX_WAIT: begin
                if (resolve) ret_wait_d = 1'b0;
                if (gmii_tx_done) begin
                    ret_wait_d = 1'b0;
                    timer_d    = timer_q;
                    if (pend_req_q) begin
                        // A new req arrived during the frame: restart the exchange.
                        state_d = IDLE;
                        timer_d = '0;
                    end else if (tx_type_q) begin
                        state_d = (ret_wait_q && !resolve) ? WAIT_REPLY : IDLE;
                    end else begin
                        if (retry_q != RETRY_LIMIT) retry_d = retry_q + RETRY_W'(1);
                        timer_d = '0;
                        state_d = resolve ? IDLE : WAIT_REPLY;
                    end
                end
            end
            WAIT_REPLY: begin
                if (resolve || pend_req_q) begin
                    state_d = IDLE;
                    timer_d = '0;
                end else if (pend_rep_q) begin
                    // Serve the requester; the timer holds until we come back.
                    state_d    = TX_START;
                    tx_en_d    = 1'b1;
                    tx_type_d  = 1'b1;
                    des_mac_d  = rep_mac_q;
                    des_ip_d   = rep_ip_q;
                    pend_rep_d = 1'b0;
                    ret_wait_d = 1'b1;
                end else if (timer_q == TIMER_LAST) begin
                    if (retry_q < RETRY_LIMIT) begin
                        state_d   = TX_START;
                        tx_en_d   = 1'b1;
                        tx_type_d = 1'b0;
                        des_mac_d = DES_MAC;
                        des_ip_d  = tgt_ip_q;
                    end else begin
                        timeout_err_d = 1'b1;
                        state_d       = IDLE;
                        timer_d       = '0;
                    end
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (resolve) begin
            res_mac_d  = src_mac;
            res_ip_d   = src_ip;
            resolved_d = 1'b1;
        end

        // New arrivals win over the clear applied when a flag is serviced.
        if (rx_req) begin
            pend_rep_d = 1'b1;
            rep_mac_d  = src_mac;
            rep_ip_d   = src_ip;
        end

        if (req) begin
            pend_req_d    = 1'b1;
            tgt_ip_d      = tgt_ip;
            retry_d       = '0;
            timeout_err_d = 1'b0;
            if (tgt_ip != res_ip_d) resolved_d = 1'b0;
        end

        busy_d = (state_d != IDLE);
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            ret_wait_q    <= 1'b0;
            pend_rep_q    <= 1'b0;
            rep_mac_q     <= '0;
            rep_ip_q      <= '0;
            pend_req_q    <= 1'b0;
            tgt_ip_q      <= '0;
            retry_q       <= '0;
            timer_q       <= '0;
            tx_en_q       <= 1'b0;
            tx_type_q     <= 1'b0;
            des_mac_q     <= DES_MAC;
            des_ip_q      <= DES_IP;
            resolved_q    <= 1'b0;
            res_mac_q     <= '0;
            res_ip_q      <= '0;
            timeout_err_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            ret_wait_q    <= ret_wait_d;
            pend_rep_q    <= pend_rep_d;
            rep_mac_q     <= rep_mac_d;
            rep_ip_q      <= rep_ip_d;
            pend_req_q    <= pend_req_d;
            tgt_ip_q      <= tgt_ip_d;
            retry_q       <= retry_d;
            timer_q       <= timer_d;
            tx_en_q       <= tx_en_d;
            tx_type_q     <= tx_type_d;
            des_mac_q     <= des_mac_d;
            des_ip_q      <= des_ip_d;
            resolved_q    <= resolved_d;
            res_mac_q     <= res_mac_d;
            res_ip_q      <= res_ip_d;
            timeout_err_q <= timeout_err_d;
            busy_q        <= busy_d;
        end
    end

    assign arp_tx_en   = tx_en_q;
    assign arp_tx_type = tx_type_q;
    assign des_mac     = des_mac_q;
    assign des_ip      = des_ip_q;
    assign resolved    = resolved_q;
    assign res_mac     = res_mac_q;
    assign res_ip      = res_ip_q;
    assign timeout_err = timeout_err_q;
    assign busy        = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_arp_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_arp_ctrl
// Description : Self-checking bench for arp_ctrl. A responder ends every
//               transmitted frame after a random length and logs it; each
//               test task predicts frame timing/contents from the ARP rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arp_ctrl;

    localparam int          RC     = 100;
    localparam int          MR     = 3;
    localparam logic [47:0] BCAST  = 48'hff_ff_ff_ff_ff_ff;
    localparam logic [31:0] RST_IP = 32'hC0A8_0003;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req = 1'b0;
    logic [31:0] tgt_ip = '0;
    logic        arp_rx_done = 1'b0;
    logic        arp_rx_type = 1'b0;
    logic [47:0] src_mac = '0;
    logic [31:0] src_ip = '0;
    logic        gmii_tx_done = 1'b0;
    logic        arp_tx_en, arp_tx_type, resolved, timeout_err, busy;
    logic [47:0] des_mac, res_mac;
    logic [31:0] des_ip, res_ip;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int          cyc;
        logic        typ;
        logic [47:0] mac;
        logic [31:0] ip;
        int          done;
    } tx_t;
    tx_t txq[$];

    arp_ctrl #(.RETRY_CYCLES(RC), .MAX_RETRY(MR)) dut (
        .clk(clk), .rst(rst), .req(req), .tgt_ip(tgt_ip),
        .arp_rx_done(arp_rx_done), .arp_rx_type(arp_rx_type),
        .src_mac(src_mac), .src_ip(src_ip), .gmii_tx_done(gmii_tx_done),
        .arp_tx_en(arp_tx_en), .arp_tx_type(arp_tx_type),
        .des_mac(des_mac), .des_ip(des_ip), .resolved(resolved),
        .res_mac(res_mac), .res_ip(res_ip), .timeout_err(timeout_err), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Frame responder and transmit logger: a frame started in cycle c ends
    // with gmii_tx_done in cycle c+len, len random.
    initial begin
        int left;
        int len;
        tx_t t;
        left = 0;
        forever begin
            @(negedge clk);
            gmii_tx_done = 1'b0;
            if (!rst) left = 0;
            else if (left > 0) begin
                left = left - 1;
                if (left == 0) gmii_tx_done = 1'b1;
            end
            if (arp_tx_en === 1'b1 && rst) begin
                len    = $urandom_range(3, 10);
                t.cyc  = cyc;
                t.typ  = arp_tx_type;
                t.mac  = des_mac;
                t.ip   = des_ip;
                t.done = cyc + len;
                left   = len;
                txq.push_back(t);
            end
        end
    end

    task automatic at_cycle(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic wait_tx(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (txq.size() > 0) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (txq.size() > 0) ok = 1'b1;
    endtask

    task automatic pulse_req(input logic [31:0] ip);
        req = 1'b1; tgt_ip = ip;
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic pulse_rx(input logic typ, input logic [47:0] mac, input logic [31:0] ip);
        arp_rx_done = 1'b1; arp_rx_type = typ; src_mac = mac; src_ip = ip;
        @(negedge clk);
        arp_rx_done = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if ({arp_tx_en, arp_tx_type, busy} !== 3'b000) begin errors++; $display("FAIL reset_ctl: got %b expected 000", {arp_tx_en, arp_tx_type, busy}); end
        checks++; if (des_mac !== BCAST) begin errors++; $display("FAIL reset_des_mac: got %h expected %h", des_mac, BCAST); end
        checks++; if (des_ip !== RST_IP) begin errors++; $display("FAIL reset_des_ip: got %h expected %h", des_ip, RST_IP); end
        checks++; if ({resolved, timeout_err} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b expected 00", {resolved, timeout_err}); end
        checks++; if ({res_mac, res_ip} !== 80'd0) begin errors++; $display("FAIL reset_res: got %h expected 0", {res_mac, res_ip}); end
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // Resolve three targets: a fixed one, a re-request of the same IP (resolved
    // must persist) and a fresh IP (resolved must clear on the req).
    task automatic test_resolve();
        logic [31:0] ip;
        logic [47:0] mac;
        logic        m_resolved;
        logic [31:0] m_res_ip;
        logic        exp_res;
        int          k;
        bit          ok;
        tx_t         t;
        m_resolved = 1'b0;
        m_res_ip   = '0;
        for (int it = 0; it < 3; it++) begin
            mac = {16'($urandom), $urandom};
            if (it == 0) begin ip = 32'hC0A8_0003; mac = 48'h00_0A_35_01_02_03; end
            else if (it == 1) ip = m_res_ip;
            else ip = {8'd10, 24'($urandom)};
            exp_res = m_resolved && (ip == m_res_ip);
            k = cyc;
            pulse_req(ip);
            checks++; if (resolved !== exp_res) begin errors++; $display("FAIL resolve_keep[%0d]: got %b expected %b", it, resolved, exp_res); end
            wait_tx(20, ok);
            checks++; if (!ok) begin errors++; $display("FAIL resolve_tx[%0d]: got no frame expected request", it); return; end
            t = txq.pop_front();
            checks++; if (t.cyc !== k + 2) begin errors++; $display("FAIL resolve_tx_cyc[%0d]: got %0d expected %0d", it, t.cyc, k + 2); end
            checks++; if ({t.typ, t.mac, t.ip} !== {1'b0, BCAST, ip}) begin errors++; $display("FAIL resolve_tx_hdr[%0d]: got %h expected %h", it, {t.typ, t.mac, t.ip}, {1'b0, BCAST, ip}); end
            at_cycle(t.done + $urandom_range(2, 20));
            pulse_rx(1'b1, mac, ip);
            checks++; if ({resolved, busy} !== 2'b10) begin errors++; $display("FAIL resolve_flag[%0d]: got %b expected 10", it, {resolved, busy}); end
            checks++; if ({res_mac, res_ip} !== {mac, ip}) begin errors++; $display("FAIL resolve_res[%0d]: got %h expected %h", it, {res_mac, res_ip}, {mac, ip}); end
            m_resolved = 1'b1;
            m_res_ip   = ip;
        end
    endtask

    task automatic test_auto_reply();
        logic [47:0] mac;
        logic [31:0] ip;
        int          q;
        bit          ok;
        tx_t         t;
        for (int it = 0; it < 2; it++) begin
            mac = (it == 0) ? 48'h10_20_30_40_50_60 : {16'($urandom), $urandom};
            ip  = (it == 0) ? 32'hC0A8_0005 : $urandom;
            q = cyc;
            pulse_rx(1'b0, mac, ip);
            wait_tx(20, ok);
            checks++; if (!ok) begin errors++; $display("FAIL reply_tx[%0d]: got no frame expected reply", it); return; end
            t = txq.pop_front();
            checks++; if (t.cyc !== q + 2) begin errors++; $display("FAIL reply_cyc[%0d]: got %0d expected %0d", it, t.cyc, q + 2); end
            checks++; if ({t.typ, t.mac, t.ip} !== {1'b1, mac, ip}) begin errors++; $display("FAIL reply_hdr[%0d]: got %h expected %h", it, {t.typ, t.mac, t.ip}, {1'b1, mac, ip}); end
            at_cycle(t.done);
            checks++; if ({arp_tx_type, des_mac, des_ip} !== {1'b1, mac, ip}) begin errors++; $display("FAIL reply_hold[%0d]: got %h expected %h", it, {arp_tx_type, des_mac, des_ip}, {1'b1, mac, ip}); end
            @(negedge clk);
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reply_idle[%0d]: got %b expected 0", it, busy); end
        end
    endtask

    // No reply ever: MR requests, each resend R+1 clocks after the previous
    // frame's done, then timeout_err one clock after the final wait expires.
    task automatic test_timeout();
        logic [31:0] ip;
        int          k;
        int          exp_cyc;
        bit          ok;
        tx_t         t;
        ip = {8'd172, 8'd20, 16'($urandom)};
        k = cyc;
        pulse_req(ip);
        exp_cyc = k + 2;
        for (int n = 0; n < MR; n++) begin
            wait_tx(RC + 40, ok);
            checks++; if (!ok) begin errors++; $display("FAIL timeout_tx[%0d]: got no frame expected request", n); return; end
            t = txq.pop_front();
            checks++; if (t.cyc !== exp_cyc) begin errors++; $display("FAIL timeout_cyc[%0d]: got %0d expected %0d", n, t.cyc, exp_cyc); end
            checks++; if ({t.typ, t.mac, t.ip} !== {1'b0, BCAST, ip}) begin errors++; $display("FAIL timeout_hdr[%0d]: got %h expected %h", n, {t.typ, t.mac, t.ip}, {1'b0, BCAST, ip}); end
            exp_cyc = t.done + RC + 1;
        end
        at_cycle(exp_cyc - 1);
        checks++; if ({timeout_err, busy} !== 2'b01) begin errors++; $display("FAIL timeout_early: got %b expected 01", {timeout_err, busy}); end
        @(negedge clk);
        checks++; if ({timeout_err, busy} !== 2'b10) begin errors++; $display("FAIL timeout_err: got %b expected 10", {timeout_err, busy}); end
        repeat (RC + 20) @(negedge clk);
        checks++; if (txq.size() !== 0 || timeout_err !== 1'b1) begin errors++; $display("FAIL timeout_final: got frames=%0d err=%b expected 0 1", txq.size(), timeout_err); end
        txq.delete();
    endtask

    // Inbound request during the wait: the reply is sent and the resend is
    // pushed back by the clocks spent serving it (after inbound request to done).
    task automatic test_interleave();
        logic [31:0] ip, rip;
        logic [47:0] rmac, mac;
        int          k, d, q, e, exp_cyc;
        bit          ok;
        tx_t         t;
        ip   = {8'd172, 8'd16, 16'($urandom)};
        rip  = $urandom;
        rmac = {16'($urandom), $urandom};
        mac  = {16'($urandom), $urandom};
        k = cyc;
        pulse_req(ip);
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL inter_err_clr: got %b expected 0", timeout_err); end
        wait_tx(20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL inter_tx0: got no frame expected request"); return; end
        t = txq.pop_front();
        checks++; if (t.cyc !== k + 2) begin errors++; $display("FAIL inter_cyc0: got %0d expected %0d", t.cyc, k + 2); end
        d = t.done;
        q = d + $urandom_range(5, 40);
        at_cycle(q);
        pulse_rx(1'b0, rmac, rip);
        wait_tx(20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL inter_reply: got no frame expected reply"); return; end
        t = txq.pop_front();
        checks++; if ({t.typ, t.mac, t.ip} !== {1'b1, rmac, rip} || t.cyc !== q + 2) begin errors++; $display("FAIL inter_reply_hdr: got %h@%0d expected %h@%0d", {t.typ, t.mac, t.ip}, t.cyc, {1'b1, rmac, rip}, q + 2); end
        e = t.done;
        exp_cyc = d + RC + 1 + (e - q);
        at_cycle(e + 1);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL inter_busy: got %b expected 1", busy); end
        wait_tx(RC + 40, ok);
        checks++; if (!ok) begin errors++; $display("FAIL inter_resend: got no frame expected request"); return; end
        t = txq.pop_front();
        checks++; if (t.cyc !== exp_cyc) begin errors++; $display("FAIL inter_resend_cyc: got %0d expected %0d", t.cyc, exp_cyc); end
        checks++; if ({t.typ, t.mac, t.ip} !== {1'b0, BCAST, ip}) begin errors++; $display("FAIL inter_resend_hdr: got %h expected %h", {t.typ, t.mac, t.ip}, {1'b0, BCAST, ip}); end
        at_cycle(t.done + 3);
        pulse_rx(1'b1, mac, ip);
        checks++; if ({resolved, res_mac, res_ip} !== {1'b1, mac, ip}) begin errors++; $display("FAIL inter_resolve: got %h expected %h", {resolved, res_mac, res_ip}, {1'b1, mac, ip}); end
    endtask

    task automatic test_wrong_ip();
        logic [31:0] ip, old_ip;
        logic [47:0] mac;
        int          d;
        bit          ok;
        tx_t         t;
        ip     = {8'd172, 8'd17, 16'($urandom)};
        mac    = {16'($urandom), $urandom};
        old_ip = res_ip;
        pulse_req(ip);
        checks++; if (resolved !== 1'b0) begin errors++; $display("FAIL wrong_clr: got %b expected 0", resolved); end
        wait_tx(20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL wrong_tx0: got no frame expected request"); return; end
        t = txq.pop_front();
        d = t.done;
        at_cycle(d + 10);
        pulse_rx(1'b1, mac, 32'hC0A8_0009);
        checks++; if ({resolved, res_ip} !== {1'b0, old_ip}) begin errors++; $display("FAIL wrong_ignored: got %h expected %h", {resolved, res_ip}, {1'b0, old_ip}); end
        wait_tx(RC + 40, ok);
        checks++; if (!ok) begin errors++; $display("FAIL wrong_resend: got no frame expected request"); return; end
        t = txq.pop_front();
        checks++; if (t.cyc !== d + RC + 1 || {t.typ, t.ip} !== {1'b0, ip}) begin errors++; $display("FAIL wrong_resend_hdr: got %h@%0d expected %h@%0d", {t.typ, t.ip}, t.cyc, {1'b0, ip}, d + RC + 1); end
        at_cycle(t.done + 2);
        pulse_rx(1'b1, mac, ip);
        checks++; if ({resolved, res_mac, res_ip} !== {1'b1, mac, ip}) begin errors++; $display("FAIL wrong_resolve: got %h expected %h", {resolved, res_mac, res_ip}, {1'b1, mac, ip}); end
    endtask

    // req while waiting: old target abandoned, new request after a pass through IDLE.
    task automatic test_back_to_back();
        logic [31:0] ip1, ip2;
        logic [47:0] mac;
        int          k;
        bit          ok;
        tx_t         t;
        ip1 = {8'd172, 8'd18, 16'($urandom)};
        ip2 = {8'd172, 8'd19, 16'($urandom)};
        mac = {16'($urandom), $urandom};
        pulse_req(ip1);
        wait_tx(20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL b2b_tx0: got no frame expected request"); return; end
        t = txq.pop_front();
        at_cycle(t.done + $urandom_range(3, 30));
        k = cyc;
        pulse_req(ip2);
        wait_tx(20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL b2b_tx1: got no frame expected request"); return; end
        t = txq.pop_front();
        checks++; if (t.cyc !== k + 3 || {t.typ, t.mac, t.ip} !== {1'b0, BCAST, ip2}) begin errors++; $display("FAIL b2b_hdr: got %h@%0d expected %h@%0d", {t.typ, t.mac, t.ip}, t.cyc, {1'b0, BCAST, ip2}, k + 3); end
        at_cycle(t.done + 2);
        pulse_rx(1'b1, mac, ip1);
        checks++; if (resolved !== 1'b0) begin errors++; $display("FAIL b2b_old_ignored: got %b expected 0", resolved); end
        pulse_rx(1'b1, mac, ip2);
        checks++; if ({resolved, res_ip} !== {1'b1, ip2}) begin errors++; $display("FAIL b2b_resolve: got %h expected %h", {resolved, res_ip}, {1'b1, ip2}); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] ip;
        int          k;
        bit          ok;
        tx_t         t;
        ip = {8'd172, 8'd21, 16'($urandom)};
        pulse_req(ip);
        wait_tx(20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rstmid_tx0: got no frame expected request"); return; end
        t = txq.pop_front();
        at_cycle(t.cyc + 1);
        #3 rst = 1'b0;
        #1;
        checks++; if ({arp_tx_en, arp_tx_type, busy, resolved, timeout_err} !== 5'b0) begin errors++; $display("FAIL rstmid_flags: got %b expected 00000", {arp_tx_en, arp_tx_type, busy, resolved, timeout_err}); end
        checks++; if ({des_mac, des_ip} !== {BCAST, RST_IP}) begin errors++; $display("FAIL rstmid_des: got %h expected %h", {des_mac, des_ip}, {BCAST, RST_IP}); end
        checks++; if ({res_mac, res_ip} !== 80'd0) begin errors++; $display("FAIL rstmid_res: got %h expected 0", {res_mac, res_ip}); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        txq.delete();
        repeat (15) @(negedge clk);
        checks++; if (txq.size() !== 0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_quiet: got frames=%0d busy=%b expected 0 0", txq.size(), busy); end
        k = cyc;
        pulse_req(ip);
        wait_tx(20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rstmid_tx1: got no frame expected request"); return; end
        t = txq.pop_front();
        checks++; if (t.cyc !== k + 2 || {t.typ, t.mac, t.ip} !== {1'b0, BCAST, ip}) begin errors++; $display("FAIL rstmid_req: got %h@%0d expected %h@%0d", {t.typ, t.mac, t.ip}, t.cyc, {1'b0, BCAST, ip}, k + 2); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_resolve();
        test_auto_reply();
        test_timeout();
        test_interleave();
        test_wrong_ip();
        test_back_to_back();
        test_reset_mid();
        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
